fc_stream_host: RTL and testbench

Host-side driver for the two valid/ready streams of a single fully-connected layer block. It holds an N-element input vector, streams that vector into the layer's input port, and collects the layer's M results into a result buffer. While collecting, it tracks the signed maximum result and its index and measures the run latency. It sits between the test/system side, which loads vectors and reads results, and the layer's input_*/output_* ports.

---
 rtl/fc_stream_host.sv | 151 +++++++++++++++
 tb/tb_fc_stream_host.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_stream_host.sv
// fc_stream_host
// Host-side driver for one fully-connected layer block. Holds an N-element
// input vector, streams it into the layer over a valid/ready port, then
// collects M results into a result buffer. While collecting it tracks the
// signed maximum result (value and index) and measures the run latency.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   start                 one-cycle run request (honoured in IDLE only)
//   load_en/addr/data     input-vector write port (honoured in IDLE only)
//   rd_addr / rd_data     result read port, registered, 1-cycle latency
//   busy, done            run status; done is a one-cycle end-of-run pulse
//   max_idx, max_val      index/value of the largest result of the last run
//   lat_cnt               first accept to last capture, saturating
//   in_valid/ready/data   stream to the layer input
//   out_valid/ready/data  stream from the layer output
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; vector loads accepted
// SEND  | presenting x_buf[send_idx] to the layer until N accepts
// RECV  | capturing layer results into y_buf until M captures
// DONE  | one-cycle done pulse, then back to IDLE
module fc_stream_host #(
    parameter int M = 16,
    parameter int N = 8,
    parameter int T = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 load_en,
    input  logic [$clog2(N)-1:0] load_addr,
    input  logic signed [T-1:0]  load_data,
    input  logic [$clog2(M)-1:0] rd_addr,
    output logic signed [T-1:0]  rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(M)-1:0] max_idx,
    output logic signed [T-1:0]  max_val,
    output logic [15:0]          lat_cnt,
    output logic                 in_valid,
    input  logic                 in_ready,
    output logic signed [T-1:0]  in_data,
    input  logic                 out_valid,
    output logic                 out_ready,
    input  logic signed [T-1:0]  out_data
);

    localparam int MW = $clog2(M);
    localparam int NW = $clog2(N);
    localparam logic [NW-1:0] LAST_SEND = NW'(N - 1);
    localparam logic [MW-1:0] LAST_RECV = MW'(M - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [NW-1:0]       send_idx;
    logic [NW-1:0]       send_nxt;
    logic [MW-1:0]       recv_idx;
    logic signed [T-1:0] x_buf [N];
    logic signed [T-1:0] y_buf [M];
    logic                accept;
    logic                capture;
    logic                lat_inc;

    // Handshake strobes are gated by state so stray layer activity outside
    // the matching phase never touches the buffers.
    assign in_valid  = (state_q == SEND);
    assign out_ready = (state_q == RECV);
    assign busy      = in_valid | out_ready;
    assign done      = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign capture   = out_ready & out_valid;
    assign send_nxt  = send_idx + NW'(1);

    // The accept cycle that starts the measurement counts as the first
    // cycle, so the count runs from the first accept through the final
    // capture inclusive.
    assign lat_inc = (state_q == RECV) || ((state_q == SEND) && (accept || send_idx != '0));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = SEND;
            SEND: if (accept && send_idx == LAST_SEND) state_d = RECV;
            RECV: if (capture && recv_idx == LAST_RECV) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            send_idx <= '0;
            recv_idx <= '0;
            in_data  <= '0;
            max_idx  <= '0;
            max_val  <= '0;
            lat_cnt  <= '0;
            rd_data  <= '0;
        end else begin
            state_q <= state_d;

            // Write-first: a read of the slot being captured sees the new value.
            if (capture && rd_addr == recv_idx) rd_data <= out_data;
            else                                rd_data <= y_buf[rd_addr];

            if (lat_inc && lat_cnt != 16'hFFFF) lat_cnt <= lat_cnt + 16'd1;

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        send_idx <= '0;
                        recv_idx <= '0;
                        in_data  <= x_buf[0];
                        max_idx  <= '0;
                        max_val  <= '0;
                        lat_cnt  <= '0;
                    end
                end
                SEND: begin
                    if (accept) begin
                        send_idx <= (send_idx == LAST_SEND) ? '0 : send_nxt;
                        if (send_idx != LAST_SEND) in_data <= x_buf[send_nxt];
                    end
                end
                RECV: begin
                    if (capture) begin
                        recv_idx <= recv_idx + MW'(1);
                        // Strictly greater keeps the lowest index on ties.
                        if (recv_idx == '0 || out_data > max_val) begin
                            max_val <= out_data;
                            max_idx <= recv_idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffers are plain storage and deliberately not reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && load_en) x_buf[load_addr] <= load_data;
        if (capture)                    y_buf[recv_idx]  <= out_data;
    end

endmodule

// File: tb/tb_fc_stream_host.sv
module tb_fc_stream_host;

    logic               clk;
    logic               reset;
    logic               start;
    logic               load_en;
    logic [2:0]         load_addr;
    logic signed [15:0] load_data;
    logic [3:0]         rd_addr;
    logic signed [15:0] rd_data;
    logic               busy;
    logic               done;
    logic [3:0]         max_idx;
    logic signed [15:0] max_val;
    logic [15:0]        lat_cnt;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;

    fc_stream_host #(.M(16), .N(8), .T(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .max_idx   (max_idx),
        .max_val   (max_val),
        .lat_cnt   (lat_cnt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Layer model stimulus and run observations
    logic signed [15:0] yv [16];
    logic signed [15:0] sent [16];
    logic [15:0]        rdy_pat;
    logic [15:0]        ov_pat;
    logic               inject;
    int                 n_sent, n_cap, hold_err;
    int                 done_cyc, last_cap_cyc, last_acc_cyc, first_or_cyc;
    logic               timed_out, busy_at_done;

    task automatic load_x();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load_en = 1'b1; load_addr = 3'(i); load_data = 16'(i + 1);
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Starts a run and plays the layer: inputs change on negedges, and DUT
    // outputs are sampled there to predict the handshakes at the next posedge.
    task automatic do_run();
        logic               stall_prev;
        logic signed [15:0] data_prev;
        n_sent = 0; n_cap = 0; hold_err = 0;
        done_cyc = -1; last_cap_cyc = -1; last_acc_cyc = -1; first_or_cyc = -1;
        stall_prev = 1'b0; data_prev = '0; busy_at_done = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (done) begin
                done_cyc = c; busy_at_done = busy;
                break;
            end
            in_ready  = rdy_pat[c % 16];
            out_valid = ov_pat[c % 16];
            out_data  = (out_valid && n_cap < 16) ? yv[n_cap] : 16'sh7FFF;
            start     = inject && (c == 2 || c == 3);
            load_en   = inject && (c == 2 || c == 3);
            load_addr = '0; load_data = 16'sd99;
            if (in_valid && stall_prev && in_data !== data_prev) hold_err++;
            if (in_valid && in_ready) begin
                if (n_sent < 16) sent[n_sent] = in_data;
                n_sent++; last_acc_cyc = c;
            end
            stall_prev = in_valid && !in_ready;
            data_prev  = in_data;
            if (out_ready && first_or_cyc < 0) first_or_cyc = c;
            if (out_valid && out_ready) begin
                n_cap++; last_cap_cyc = c;
            end
            @(negedge clk);
        end
        timed_out = (done_cyc < 0);
        start = 1'b0; load_en = 1'b0; in_ready = 1'b0; out_valid = 1'b0; out_data = '0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_valid, out_ready, busy, done} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {in_valid, out_ready, busy, done});
        else passed++;
        checks++;
        if (in_data !== 16'sd0 || rd_data !== 16'sd0) $display("FAIL reset_data in_data=%0d rd_data=%0d want 0", in_data, rd_data);
        else passed++;
        checks++;
        if (max_idx !== 4'd0 || max_val !== 16'sd0 || lat_cnt !== 16'd0) $display("FAIL reset_stats idx=%0d val=%0d lat=%0d want 0", max_idx, max_val, lat_cnt);
        else passed++;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_unloaded_run();
        rdy_pat = 16'hFFFF; ov_pat = 16'hFFFF;
        for (int j = 0; j < 16; j++) yv[j] = 16'(j);
        do_run();
        checks++;
        if (timed_out || n_sent != 8 || n_cap != 16) $display("FAIL unloaded_run timeout=%0d sends=%0d caps=%0d want 0/8/16", timed_out, n_sent, n_cap);
        else passed++;
    endtask

    task automatic test_basic();
        load_x();
        rdy_pat = 16'hFFFF; ov_pat = 16'hFFFF;
        for (int j = 0; j < 16; j++) yv[j] = 16'(j - 8);
        do_run();
        checks++;
        if (timed_out) $display("FAIL basic_timeout no done");
        else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sent[i] !== 16'(i + 1)) $display("FAIL basic_send[%0d] got %0d want %0d", i, sent[i], i + 1);
            else passed++;
        end
        checks++;
        if (last_acc_cyc != 7 || first_or_cyc != 8) $display("FAIL basic_handoff last_acc=%0d first_ready=%0d want 7/8", last_acc_cyc, first_or_cyc);
        else passed++;
        checks++;
        if (last_cap_cyc != 23 || done_cyc != 24 || busy_at_done !== 1'b0) $display("FAIL basic_done last_cap=%0d done=%0d busy=%0d want 23/24/0", last_cap_cyc, done_cyc, busy_at_done);
        else passed++;
        checks++;
        if (max_idx !== 4'd15 || max_val !== 16'sd7) $display("FAIL basic_max idx=%0d val=%0d want 15/7", max_idx, max_val);
        else passed++;
        checks++;
        if (lat_cnt !== 16'd24) $display("FAIL basic_lat got %0d want 24", lat_cnt);
        else passed++;
        for (int j = 0; j < 16; j++) begin
            rd_addr = 4'(j);
            @(negedge clk);
            checks++;
            if (rd_data !== 16'(j - 8)) $display("FAIL basic_ybuf[%0d] got %0d want %0d", j, rd_data, j - 8);
            else passed++;
        end
        checks++;
        if (max_idx !== 4'd15 || max_val !== 16'sd7 || lat_cnt !== 16'd24) $display("FAIL basic_hold idx=%0d val=%0d lat=%0d want 15/7/24", max_idx, max_val, lat_cnt);
        else passed++;
    endtask

    task automatic test_backpressure();
        // Cycle c uses bit c: ready 1,0,0,1,0,1,1,0,0,1,0,1,0,0,1,1
        rdy_pat = 16'b1100_1010_0110_1001;
        ov_pat  = 16'b1011_0010_1100_1101;
        for (int j = 0; j < 16; j++) yv[j] = 16'(100 - 10 * j);
        do_run();
        checks++;
        if (timed_out || n_sent != 8 || hold_err != 0) $display("FAIL bp_send timeout=%0d sends=%0d hold_err=%0d want 0/8/0", timed_out, n_sent, hold_err);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sent[i] !== 16'(i + 1)) $display("FAIL bp_send[%0d] got %0d want %0d", i, sent[i], i + 1);
            else passed++;
        end
        checks++;
        if (n_cap != 16 || done_cyc != last_cap_cyc + 1) $display("FAIL bp_caps caps=%0d done=%0d last_cap=%0d", n_cap, done_cyc, last_cap_cyc);
        else passed++;
        checks++;
        if (max_idx !== 4'd0 || max_val !== 16'sd100) $display("FAIL bp_max idx=%0d val=%0d want 0/100", max_idx, max_val);
        else passed++;
        for (int j = 0; j < 16; j++) begin
            rd_addr = 4'(j);
            @(negedge clk);
            checks++;
            if (rd_data !== 16'(100 - 10 * j)) $display("FAIL bp_ybuf[%0d] got %0d want %0d", j, rd_data, 100 - 10 * j);
            else passed++;
        end
    endtask

    task automatic test_max_ties();
        rdy_pat = 16'hFFFF; ov_pat = 16'hFFFF;
        for (int j = 0; j < 16; j++) yv[j] = -16'sd5;
        do_run();
        checks++;
        if (timed_out || max_idx !== 4'd0 || max_val !== -16'sd5) $display("FAIL ties_neg idx=%0d val=%0d want 0/-5", max_idx, max_val);
        else passed++;
        yv[3] = 16'sd100; yv[9] = 16'sd100;
        do_run();
        checks++;
        if (timed_out || max_idx !== 4'd3 || max_val !== 16'sd100) $display("FAIL ties_eq idx=%0d val=%0d want 3/100", max_idx, max_val);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        rdy_pat = 16'hFFFF; ov_pat = 16'hFFFF;
        for (int j = 0; j < 16; j++) yv[j] = 16'(j);
        inject = 1'b1;
        do_run();
        inject = 1'b0;
        checks++;
        if (timed_out || n_sent != 8 || n_cap != 16) $display("FAIL ignore_run timeout=%0d sends=%0d caps=%0d want 0/8/16", timed_out, n_sent, n_cap);
        else passed++;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL ignore_restart busy=%0d want 0", busy);
        else passed++;
        do_run();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sent[i] !== 16'(i + 1)) $display("FAIL ignore_xbuf[%0d] got %0d want %0d", i, sent[i], i + 1);
            else passed++;
        end
    endtask

    task automatic test_reset_midrun();
        int done_seen;
        in_ready = 1'b1; out_valid = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (in_valid !== 1'b0 || busy !== 1'b0 || out_ready !== 1'b0) $display("FAIL rst_async in_valid=%0d busy=%0d out_ready=%0d want 0", in_valid, busy, out_ready);
        else passed++;
        @(negedge clk); reset = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        in_ready = 1'b0;
        checks++;
        if (done_seen != 0) $display("FAIL rst_idle done_or_busy_cycles=%0d want 0", done_seen);
        else passed++;
        rdy_pat = 16'hFFFF; ov_pat = 16'hFFFF;
        do_run();
        checks++;
        if (timed_out || n_sent != 8 || sent[0] !== 16'sd1 || sent[7] !== 16'sd8) $display("FAIL rst_rerun timeout=%0d sends=%0d first=%0d last=%0d want 0/8/1/8", timed_out, n_sent, sent[0], sent[7]);
        else passed++;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        rd_addr = '0; in_ready = 1'b0; out_valid = 1'b0; out_data = '0; inject = 1'b0;
        rdy_pat = 16'hFFFF; ov_pat = 16'hFFFF;
        test_reset();
        test_unloaded_run();
        test_basic();
        test_backpressure();
        test_max_ties();
        test_busy_ignore();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
